// File: rtl/sample_merge_pkg.sv
// ============================================================================
// Module   : sample_merge_pkg
// Purpose  : Shared constants, FSM encoding and din_iq slicing for the merge arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sample_merge_pkg;

    localparam int NUM_CH       = 4;
    localparam int IQ_WIDTH     = 24;
    localparam int CH_IDX_WIDTH = 2;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Channel 0 sits in the most significant slice of the packed bus.
    function automatic logic [IQ_WIDTH-1:0] chan_slice(
        input logic [NUM_CH*IQ_WIDTH-1:0] iq,
        input logic [CH_IDX_WIDTH-1:0]    ch
    );
        return iq[(NUM_CH-1-int'(ch))*IQ_WIDTH +: IQ_WIDTH];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// Module   : sample_fifo
// Purpose  : Synchronous FIFO; head word visible on dout, push on full allowed only with pop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // When full, the write lands in the slot being read out on the same edge.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

`default_nettype wire

// File: rtl/sample_merge_arbiter.sv
// ============================================================================
// Module   : sample_merge_arbiter
// Purpose  : Four per-channel FIFOs drained round-robin with a burst limit onto a
//            ready/valid stream; optional drop counters under SAMPLE_MERGE_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_merge_arbiter
    import sample_merge_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                       data_clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          din_valid,
    input  logic [NUM_CH*IQ_WIDTH-1:0] din_iq,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [IQ_WIDTH-1:0]        m_iq,
    output logic [CH_IDX_WIDTH-1:0]    m_chan,
    output logic                       m_last,
    output logic [NUM_CH-1:0]          ovf,
    input  logic                       ovf_clr,
    output logic [NUM_CH*16-1:0]       drop_cnt
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W = $clog2(BURST_MAX) + 1;

    arb_state_e                  state_q,    state_d;
    logic [CH_IDX_WIDTH-1:0]     grant_q,    grant_d;
    logic [CH_IDX_WIDTH-1:0]     rr_ptr_q,   rr_ptr_d;
    logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic                        m_valid_q,  m_valid_d;
    logic [IQ_WIDTH-1:0]         m_iq_q,     m_iq_d;
    logic [CH_IDX_WIDTH-1:0]     m_chan_q,   m_chan_d;
    logic                        m_last_q,   m_last_d;
    logic [NUM_CH-1:0]           ovf_q,      ovf_d;

    logic [NUM_CH-1:0]           wr_req;
    logic [NUM_CH-1:0]           drop;
    logic [NUM_CH-1:0]           fifo_push;
    logic [NUM_CH-1:0]           fifo_pop;
    logic [NUM_CH-1:0]           fifo_full;
    logic [NUM_CH-1:0]           fifo_empty;
    logic [IQ_WIDTH-1:0]         fifo_dout  [NUM_CH];
    logic [CNT_W-1:0]            fifo_count [NUM_CH];

    logic                        found;
    logic                        last_beat;
    logic [CH_IDX_WIDTH-1:0]     search_idx;

    // A full FIFO still takes a sample if its head leaves on the same edge.
    assign wr_req    = din_valid & {NUM_CH{enable}};
    assign drop      = wr_req & fifo_full & ~fifo_pop;
    assign fifo_push = wr_req & ~drop;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
            sample_fifo #(
                .WIDTH (IQ_WIDTH),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (data_clk),
                .rst   (rst),
                .push  (fifo_push[i]),
                .pop   (fifo_pop[i]),
                .din   (chan_slice(din_iq, CH_IDX_WIDTH'(i))),
                .dout  (fifo_dout[i]),
                .full  (fifo_full[i]),
                .empty (fifo_empty[i]),
                .count (fifo_count[i])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        m_valid_d  = m_valid_q && !m_ready;
        m_iq_d     = m_iq_q;
        m_chan_d   = m_chan_q;
        m_last_d   = m_last_q;
        fifo_pop   = '0;
        found      = 1'b0;
        last_beat  = 1'b0;
        search_idx = '0;

        case (state_q)
            ARB: begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    search_idx = rr_ptr_q + CH_IDX_WIDTH'(k);
                    if (!found && !fifo_empty[search_idx]) begin
                        found   = 1'b1;
                        grant_d = search_idx;
                    end
                end
                if (found) begin
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if ((!m_valid_q || m_ready) && !fifo_empty[grant_q]) begin
                    // Burst ends on the limit or when the queue runs dry; later pushes wait.
                    last_beat = (beat_cnt_q == BEAT_W'(BURST_MAX - 1)) ||
                                (fifo_count[grant_q] == CNT_W'(1));
                    fifo_pop[grant_q] = 1'b1;
                    m_valid_d  = 1'b1;
                    m_iq_d     = fifo_dout[grant_q];
                    m_chan_d   = grant_q;
                    m_last_d   = last_beat;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        rr_ptr_d = grant_q;
                        state_d  = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Set takes priority over clear on the same edge.
    assign ovf_d = (ovf_q & ~{NUM_CH{ovf_clr}}) | drop;

    always_ff @(posedge data_clk) begin
        if (rst) begin
            state_q    <= ARB;
            grant_q    <= '0;
            rr_ptr_q   <= CH_IDX_WIDTH'(NUM_CH - 1);
            beat_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            m_iq_q     <= '0;
            m_chan_q   <= '0;
            m_last_q   <= 1'b0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            m_valid_q  <= m_valid_d;
            m_iq_q     <= m_iq_d;
            m_chan_q   <= m_chan_d;
            m_last_q   <= m_last_d;
            ovf_q      <= ovf_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_iq    = m_iq_q;
    assign m_chan  = m_chan_q;
    assign m_last  = m_last_q;
    assign ovf     = ovf_q;

`ifdef SAMPLE_MERGE_DROP_CNT_EN
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_drop_cnt
            logic [15:0] cnt_q, cnt_d, cnt_base;
            // Clear is applied first so a drop on the clearing edge leaves 1.
            always_comb begin
                cnt_base = ovf_clr ? 16'd0 : cnt_q;
                cnt_d    = cnt_base;
                if (drop[i] && (cnt_base != 16'hFFFF)) begin
                    cnt_d = cnt_base + 16'd1;
                end
            end
            always_ff @(posedge data_clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
            assign drop_cnt[(NUM_CH-1-i)*16 +: 16] = cnt_q;
        end
    endgenerate
`else
    assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_merge_arbiter.sv
// ============================================================================
// Module   : tb_sample_merge_arbiter
// Purpose  : Scenario tasks with a queue of expected output beats for sample_merge_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sample_merge_arbiter;

    localparam int FIFO_DEPTH = 8;
    localparam int BURST_MAX  = 4;

    logic        data_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  din_valid;
    logic [95:0] din_iq;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_iq;
    logic [1:0]  m_chan;
    logic        m_last;
    logic [3:0]  ovf;
    logic        ovf_clr;
    logic [63:0] drop_cnt;

    typedef logic [26:0] beat_t;   // {chan, iq, last}
    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    sample_merge_arbiter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BURST_MAX  (BURST_MAX)
    ) dut (
        .data_clk  (data_clk),
        .rst       (rst),
        .enable    (enable),
        .din_valid (din_valid),
        .din_iq    (din_iq),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_iq      (m_iq),
        .m_chan    (m_chan),
        .m_last    (m_last),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .drop_cnt  (drop_cnt)
    );

    always #5 data_clk = ~data_clk;

    function automatic beat_t mk(input int ch, input logic [23:0] iq, input logic last);
        return {ch[1:0], iq, last};
    endfunction

    task automatic set_slice(input int ch, input logic [23:0] v);
        din_iq[(3-ch)*24 +: 24] = v;
    endtask

    task automatic tick();
        @(posedge data_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; din_valid = '0; din_iq = '0; m_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) @(posedge data_clk);
        #1 rst = 1'b0;
        @(negedge data_clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_iq !== 24'h0) begin n_bad++; $display("FAIL reset_m_iq: got %h want 000000", m_iq); end
        n_cmp++; if (m_chan !== 2'd0) begin n_bad++; $display("FAIL reset_m_chan: got %0d want 0", m_chan); end
        n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_m_last: got %b want 0", m_last); end
        n_cmp++; if (ovf !== 4'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
        n_cmp++; if (drop_cnt !== 64'h0) begin n_bad++; $display("FAIL reset_drop_cnt: got %h want 0", drop_cnt); end
    endtask

    // All channels push 6 samples together; channel 0 wins first.
    task automatic test_round_robin();
        for (int c = 0; c < 4; c++)
            for (int n = 0; n < 4; n++)
                exp_q.push_back(mk(c, {4'hA, 4'(c), 8'(n), 8'h5A}, n == 3));
        for (int c = 0; c < 4; c++)
            for (int n = 4; n < 6; n++)
                exp_q.push_back(mk(c, {4'hA, 4'(c), 8'(n), 8'h5A}, n == 5));
        m_ready = 1'b1;
        fork
            begin
                for (int n = 0; n < 6; n++) begin
                    for (int c = 0; c < 4; c++) set_slice(c, {4'hA, 4'(c), 8'(n), 8'h5A});
                    din_valid = 4'hF;
                    tick();
                end
                din_valid = '0;
            end
            begin
                int    cyc;
                beat_t e;
                cyc = 0;
                while (exp_q.size() > 0 && cyc < 200) begin
                    @(negedge data_clk);
                    cyc++;
                    if (m_valid && m_ready) begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if ({m_chan, m_iq, m_last} !== e) begin
                            n_bad++;
                            $display("FAIL rr_beat: got %h want %h ({chan,iq,last})", {m_chan, m_iq, m_last}, e);
                        end
                    end
                end
            end
        join
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL rr_timeout: %0d beats missing, want 0", exp_q.size()); exp_q.delete();
        end
        repeat (3) @(negedge data_clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rr_idle: got m_valid=%b want 0", m_valid); end
    endtask

    task automatic test_single_latency();
        beat_t e;
        m_ready = 1'b1;
        set_slice(2, 24'hABC123);
        din_valid = 4'b0100;
        exp_q.push_back(mk(2, 24'hABC123, 1'b1));
        @(posedge data_clk);                // edge k
        #1 din_valid = '0;
        @(negedge data_clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL lat_k: got m_valid=%b want 0", m_valid); end
        @(negedge data_clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL lat_k1: got m_valid=%b want 0", m_valid); end
        @(negedge data_clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({m_valid, m_chan, m_iq, m_last} !== {1'b1, e}) begin
            n_bad++; $display("FAIL lat_k2: got %h want %h ({valid,chan,iq,last})", {m_valid, m_chan, m_iq, m_last}, {1'b1, e});
        end
        @(negedge data_clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_once: got m_valid=%b want 0", m_valid); end
    endtask

    // A stalled channel-0 beat occupies the output register, so channel 1 can hold only
    // FIFO_DEPTH samples: 10 pushes drop 2.
    task automatic test_overflow();
        int    cyc;
        beat_t e;
        m_ready = 1'b0;
        set_slice(0, 24'h0C0C0C);
        din_valid = 4'b0001;
        exp_q.push_back(mk(0, 24'h0C0C0C, 1'b1));
        tick();
        din_valid = '0;
        repeat (3) tick();
        for (int n = 0; n < 10; n++) begin
            set_slice(1, {8'h11, 8'(n), 8'hEE});
            if (n < 8) exp_q.push_back(mk(1, {8'h11, 8'(n), 8'hEE}, (n == 3) || (n == 7)));
            din_valid = 4'b0010;
            tick();
        end
        din_valid = '0;
        tick();
        @(negedge data_clk);
        n_cmp++; if (ovf !== 4'b0010) begin n_bad++; $display("FAIL ovf_ch1: got %b want 0010", ovf); end
`ifdef SAMPLE_MERGE_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 64'h0000_0002_0000_0000) begin n_bad++; $display("FAIL drop_cnt_ch1: got %h want 0000000200000000", drop_cnt); end
`else
        n_cmp++; if (drop_cnt !== 64'h0) begin n_bad++; $display("FAIL drop_cnt_off: got %h want 0", drop_cnt); end
`endif
        tick();
        m_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge data_clk);
            cyc++;
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({m_chan, m_iq, m_last} !== e) begin
                    n_bad++; $display("FAIL ovf_beat: got %h want %h ({chan,iq,last})", {m_chan, m_iq, m_last}, e);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL ovf_timeout: %0d beats missing, want 0", exp_q.size()); exp_q.delete();
        end
        repeat (3) @(negedge data_clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_extra: got m_valid=%b want 0", m_valid); end
        n_cmp++; if (ovf !== 4'b0010) begin n_bad++; $display("FAIL ovf_sticky: got %b want 0010", ovf); end
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge data_clk);
        n_cmp++; if ({ovf, drop_cnt} !== 68'h0) begin n_bad++; $display("FAIL ovf_clear: got ovf=%b drop_cnt=%h want 0/0", ovf, drop_cnt); end
    endtask

    task automatic test_stall();
        int    cyc;
        logic  stalled;
        beat_t held;
        beat_t e;
        m_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            set_slice(3, {8'h33, 8'(n), 8'h99});
            exp_q.push_back(mk(3, {8'h33, 8'(n), 8'h99}, (n == 3) || (n == 5)));
            din_valid = 4'b1000;
            tick();
        end
        din_valid = '0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(posedge data_clk);
            #1 m_ready = ((cyc % 3) != 1);
            cyc++;
            @(negedge data_clk);
            if (stalled) begin
                n_cmp++;
                if ({m_valid, m_chan, m_iq, m_last} !== {1'b1, held}) begin
                    n_bad++; $display("FAIL stall_hold: got %h want %h ({valid,chan,iq,last})", {m_valid, m_chan, m_iq, m_last}, {1'b1, held});
                end
            end
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({m_chan, m_iq, m_last} !== e) begin
                    n_bad++; $display("FAIL stall_beat: got %h want %h ({chan,iq,last})", {m_chan, m_iq, m_last}, e);
                end
            end
            stalled = m_valid && !m_ready;
            held    = {m_chan, m_iq, m_last};
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL stall_timeout: %0d beats missing, want 0", exp_q.size()); exp_q.delete();
        end
        m_ready = 1'b1;
        repeat (3) @(negedge data_clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL stall_extra: got m_valid=%b want 0", m_valid); end
    endtask

    // 9 samples fill the output register plus FIFO 0; the 10th drops while ovf_clr is high.
    task automatic test_ovf_clr_same_edge();
        int    cyc;
        beat_t e;
        m_ready = 1'b0;
        for (int n = 0; n < 9; n++) begin
            set_slice(0, {8'hC0, 8'(n), 8'h33});
            exp_q.push_back(mk(0, {8'hC0, 8'(n), 8'h33}, (n == 3) || (n == 7) || (n == 8)));
            din_valid = 4'b0001;
            tick();
        end
        din_valid = '0;
        tick();
        @(negedge data_clk);
        n_cmp++; if (ovf !== 4'b0000) begin n_bad++; $display("FAIL clr_pre_ovf: got %b want 0000", ovf); end
        tick();
        set_slice(0, 24'hDEAD00);
        din_valid = 4'b0001;
        ovf_clr   = 1'b1;
        tick();
        din_valid = '0;
        ovf_clr   = 1'b0;
        @(negedge data_clk);
        n_cmp++; if (ovf !== 4'b0001) begin n_bad++; $display("FAIL clr_set_wins: got %b want 0001", ovf); end
`ifdef SAMPLE_MERGE_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 64'h0001_0000_0000_0000) begin n_bad++; $display("FAIL clr_inc_wins: got %h want 0001000000000000", drop_cnt); end
`else
        n_cmp++; if (drop_cnt !== 64'h0) begin n_bad++; $display("FAIL clr_drop_off: got %h want 0", drop_cnt); end
`endif
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge data_clk);
        n_cmp++; if ({ovf, drop_cnt} !== 68'h0) begin n_bad++; $display("FAIL clr_plain: got ovf=%b drop_cnt=%h want 0/0", ovf, drop_cnt); end
        tick();
        m_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge data_clk);
            cyc++;
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({m_chan, m_iq, m_last} !== e) begin
                    n_bad++; $display("FAIL clr_beat: got %h want %h ({chan,iq,last})", {m_chan, m_iq, m_last}, e);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL clr_timeout: %0d beats missing, want 0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_burst();
        int    cyc;
        logic  seen;
        beat_t e;
        m_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            set_slice(2, {8'h22, 8'(n), 8'h77});
            din_valid = 4'b0100;
            tick();
        end
        din_valid = '0;
        repeat (2) tick();
        @(negedge data_clk);
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1", m_valid); end
        tick();
        rst     = 1'b1;
        m_ready = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge data_clk);
        n_cmp++;
        if ({m_valid, m_chan, m_iq, m_last, ovf, drop_cnt} !== 96'h0) begin
            n_bad++; $display("FAIL mid_reset_outs: got valid=%b chan=%0d iq=%h last=%b ovf=%b drop=%h want all 0",
                              m_valid, m_chan, m_iq, m_last, ovf, drop_cnt);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge data_clk);
            if (m_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_stale: got stale beat=%b want 0", seen); end
        tick();
        set_slice(1, 24'h5A5A5A);
        din_valid = 4'b0010;
        exp_q.push_back(mk(1, 24'h5A5A5A, 1'b1));
        tick();
        din_valid = '0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            @(negedge data_clk);
            cyc++;
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({m_chan, m_iq, m_last} !== e) begin
                    n_bad++; $display("FAIL mid_fresh: got %h want %h ({chan,iq,last})", {m_chan, m_iq, m_last}, e);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL mid_timeout: %0d beats missing, want 0", exp_q.size()); exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_latency();
        test_overflow();
        test_stall();
        test_ovf_clr_same_edge();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/sample_merge_arbiter.md
Name: sample_merge_arbiter

Overview:
- Merges the four per-channel filtered IQ streams from the sample filter into one ready/valid output stream, tagged with a channel index.
- Each channel has a small FIFO because the filter outputs are valid-only and cannot be back-pressured.
- A round-robin scheduler with a burst limit drains the FIFOs toward the packetiser/DMA.
- Overflow is flagged per channel with sticky flags.

Parameters:
- FIFO_DEPTH, 8, per-channel FIFO entries; power of two, minimum 2.
- BURST_MAX, 4, maximum consecutive beats granted to one channel before re-arbitration; range 1..FIFO_DEPTH.

Ports:
- data_clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, FIFO writes are blocked; draining continues.
- din_valid  in  4  per-channel sample strobe; bit i is channel i.
- din_iq  in  96  packed samples. Channel 0 occupies [95:72], channel 3 occupies [23:0]. Within each 24-bit slice, I is in the upper 12 bits and Q in the lower 12.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_iq  out  24  {I,Q} of the current beat.
- m_chan  out  2  source channel of the current beat.
- m_last  out  1  last beat of the current burst.
- ovf  out  4  sticky overflow flag per channel.
- ovf_clr  in  1  clears ovf (and drop_cnt when the optional feature is compiled in).
- drop_cnt  out  64  four 16-bit drop counters; channel 0 in [63:48].

Behaviour:
- Reset values:
  - m_valid=0, m_iq=0, m_chan=0, m_last=0, ovf=0, drop_cnt=0.
  - All FIFOs empty; state=ARB; rr_ptr=3, so channel 0 has first priority.
  - Reset mid-burst flushes all stored data. m_valid is low after the reset edge, regardless of m_ready.
- Write:
  - On an edge with din_valid[i] && enable, din_iq slice i is pushed into FIFO i.
  - If FIFO i is full and is not popped on the same edge, the sample is dropped and ovf[i] is set.
  - A simultaneous push and pop on a full FIFO is accepted with no drop.
- Output register follows AXI-stream rules: m_iq, m_chan and m_last are held stable while m_valid && !m_ready. A beat is transferred on an edge with m_valid && m_ready.
- FSM state ARB:
  - Search channels rr_ptr+1, rr_ptr+2, … modulo 4 for the first non-empty FIFO.
  - If one is found: latch grant=ch, set beat_cnt=0, go to XFER. Otherwise stay in ARB.
  - No output beat is loaded while in ARB.
- FSM state XFER:
  - When the output register is empty, or is being accepted this edge, pop the head of FIFO grant into the register.
  - On that load: m_valid=1, m_chan=grant, beat_cnt++.
  - m_last=1 if beat_cnt+1==BURST_MAX, or if FIFO grant holds exactly 1 entry at the pop.
  - After the pop with m_last=1: rr_ptr=grant, go to ARB. The final beat can still be awaiting m_ready while in ARB.
  - A concurrent push to the granted channel does not extend the burst.
- Latency: a sample written on edge k with all FIFOs previously empty and m_ready=1 gives m_valid=1 after edge k+2.
- Throughput: the 1-cycle ARB gap between bursts is accepted.
- With enable low, the current burst completes and the FIFOs drain to empty.
- ovf_clr and a new overflow on the same edge: set wins.

Optional Feature:
- Macro SAMPLE_MERGE_DROP_CNT_EN.
- Defined: drop_cnt[i] increments on each dropped sample of channel i, saturates at 16'hFFFF, and is cleared by ovf_clr. Increment wins over clear on the same edge, so the counter is 1 after that edge.
- Not defined: drop_cnt is tied to 0 and no counter logic is generated.

Decomposition:
- Package sample_merge_pkg holds:
  - NUM_CH=4, IQ_WIDTH=24, CH_IDX_WIDTH=2.
  - The FSM state encoding (ARB, XFER).
  - A function returning the din_iq slice for a channel index.
- One sub-module, sample_fifo: synchronous FIFO.
  - Parameters WIDTH and DEPTH.
  - Signals push, pop, din, dout (registered head), full, empty, count.
  - Instantiated four times in a generate loop.

Test Plan:
- Single sample 0xABC_123 on channel 2 at edge k, m_ready=1 → m_valid after edge k+2 with m_iq=24'hABC123, m_chan=2, m_last=1; one beat only.
- All four channels each push 6 samples together, BURST_MAX=4 → output channel order 0(4),1(4),2(4),3(4),0(2),1(2),2(2),3(2). m_last on every 4th beat of each channel's first burst and on the final beat of each 2-beat burst.
- Channel 1 pushes 10 samples with m_ready=0, FIFO_DEPTH=8 → ovf=4'b0010, 2 samples dropped. drop_cnt[47:32]=2 with the macro, 0 without. After m_ready=1, exactly 8 beats are output in order.
- m_ready toggled 1-0-1 mid-burst → m_iq, m_chan and m_last stay stable during stall cycles; no beat is lost or duplicated.
- rst asserted in XFER with 3 entries queued → all outputs at reset values after the edge; no stale beat appears after rst is released.
- ovf_clr on the same edge as a new overflow on channel 0 → ovf[0] remains 1.
